// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//
// Sequences one operation on the shared multiply/divide unit of the multicycle
// CPU. It accepts a single-cycle start request from the main control unit,
// issues the init strobe to the multiplier or the divider, and waits out the
// unit latency with a down-counter. It then pulses the HI/LO load and reports
// completion. A divide by a zero divisor never starts the divider; it raises
// a one-cycle exception pulse instead.
//
// Parameters
//   MULT_CYCLES   multiplier latency after its init strobe (1..255)
//   DIV_CYCLES    divider latency after its init strobe (1..255)
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   start         operation request, only sampled while idle
//   op            0 MULT, 1 DIV (dividend A), 2 DIVM (dividend MDR), 3 reserved
//   divisor_zero  divisor equals zero, sampled together with start
//   abort         cancel: return to idle on the next edge
//   busy          high whenever not idle
//   mult_init     one-cycle multiplier start strobe
//   div_init      one-cycle divider start strobe
//   div_src_sel   dividend mux select (0 = A, 1 = MDR)
//   hl_src_sel    HI/LO mux select (0 = divider, 1 = multiplier)
//   hl_load       one-cycle HI/LO load enable
//   done          one-cycle completion pulse
//   div_zero_exc  one-cycle divide-by-zero exception pulse
//
// All outputs are decoded from registered state only, so no input reaches an
// output combinationally and every output is 0 as soon as reset asserts.
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int unsigned MULT_CYCLES = 32,
    parameter int unsigned DIV_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic       divisor_zero,
    input  logic       abort,
    output logic       busy,
    output logic       mult_init,
    output logic       div_init,
    output logic       div_src_sel,
    output logic       hl_src_sel,
    output logic       hl_load,
    output logic       done,
    output logic       div_zero_exc
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_DZERO = 3'd5;

    // Counter preload is N-1 so that RUN lasts exactly N cycles.
    localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES - 32'd1);
    localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES - 32'd1);

    logic [2:0] r_state;
    logic [7:0] r_cnt;
    logic       r_kind_mult;   // 1 = multiply, 0 = divide
    logic       r_div_src;     // latched op == DIVM

    logic [2:0] w_state_nxt;
    logic [7:0] w_cnt_nxt;
    logic       w_kind_nxt;
    logic       w_div_src_nxt;
    logic       w_active;      // INIT through DONE: mux selects are valid

    // Next-state, counter and operation-latch logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_kind_nxt    = r_kind_mult;
        w_div_src_nxt = r_div_src;
        if (abort) begin
            // Abort beats everything, including a start seen in IDLE.
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && (op != 2'd3)) begin
                        w_kind_nxt    = (op == 2'd0);
                        w_div_src_nxt = (op == 2'd2);
                        if ((op != 2'd0) && divisor_zero) begin
                            w_state_nxt = S_DZERO;
                        end else begin
                            w_state_nxt = S_INIT;
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_INIT: begin
                    if (r_kind_mult) begin
                        w_cnt_nxt = MULT_LOAD;
                    end else begin
                        w_cnt_nxt = DIV_LOAD;
                    end
                    w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    // Counter saturates at 0: leave RUN instead of wrapping.
                    if (r_cnt == 8'd0) begin
                        w_state_nxt = S_WRITE;
                    end else begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
                S_WRITE: w_state_nxt = S_DONE;
                S_DONE:  w_state_nxt = S_IDLE;
                S_DZERO: w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_kind_mult <= 1'b0;
            r_div_src   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_kind_mult <= w_kind_nxt;
            r_div_src   <= w_div_src_nxt;
        end
    end

    // Output decode from the registered state only.
    always_comb begin
        w_active     = (r_state == S_INIT) || (r_state == S_RUN) ||
                       (r_state == S_WRITE) || (r_state == S_DONE);
        busy         = (r_state != S_IDLE);
        mult_init    = (r_state == S_INIT) && r_kind_mult;
        div_init     = (r_state == S_INIT) && !r_kind_mult;
        hl_src_sel   = w_active && r_kind_mult;
        div_src_sel  = w_active && r_div_src;
        hl_load      = (r_state == S_WRITE);
        done         = (r_state == S_DONE);
        div_zero_exc = (r_state == S_DZERO);
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Sequencer for the multicycle CPU's shared multiply/divide resource. The main control unit issues a single-cycle `start` with an operation code. The block then drives the `mult`/`div` start strobes, the dividend-source mux select and the HI/LO source mux select, and waits out the unit latency. It finally pulses the HI/LO register load and reports `done`. Division by zero is intercepted before the divider is started and reported as an exception pulse, so the main FSM only waits on `done` or `div_zero_exc`.

## Interface
- `MULT_CYCLES`, default 32: cycles the multiplier needs after its init strobe; valid range 1..255.
- `DIV_CYCLES`, default 32: cycles the divider needs after its init strobe; valid range 1..255.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  operation request; sampled only in IDLE.
- `op`  in  2  operation code:
  - 0: MULT
  - 1: DIV, dividend from A
  - 2: DIVM, dividend from MDR
  - 3: reserved
- `divisor_zero`  in  1  divisor (B) equals zero; sampled together with `start`.
- `abort`  in  1  cancel request from the control unit (exception or flush).
- `busy`  out  1  high in every state except IDLE.
- `mult_init`  out  1  one-cycle start strobe to the multiplier.
- `div_init`  out  1  one-cycle start strobe to the divider.
- `div_src_sel`  out  1  dividend mux select: 0 = A, 1 = MDR.
- `hl_src_sel`  out  1  HI/LO mux select: 0 = divider, 1 = multiplier.
- `hl_load`  out  1  one-cycle load enable for HI and LO.
- `done`  out  1  one-cycle completion pulse.
- `div_zero_exc`  out  1  one-cycle divide-by-zero exception pulse.

## Operation
- States: IDLE, INIT, RUN, WRITE, DONE, DZERO.
- IDLE
  - `start`=1 with `op`=0: go to INIT; latch kind=MULT, N=`MULT_CYCLES`.
  - `start`=1 with `op`=1 or 2: if `divisor_zero`=1 go to DZERO; otherwise go to INIT with kind=DIV, N=`DIV_CYCLES`.
  - `op`=3: `start` is ignored and the block stays in IDLE.
  - `div_src_sel` is latched as `op`==2.
- INIT
  - `mult_init` or `div_init` is driven high according to kind.
  - The down-counter is loaded with N-1.
  - Next state is RUN.
- RUN
  - The counter decrements each cycle.
  - When the counter is 0, go to WRITE. The counter does not decrement below 0.
- WRITE: `hl_load`=1; next state DONE.
- DONE: `done`=1; next state IDLE.
- DZERO: `div_zero_exc`=1; no init strobe and no `hl_load`; next state IDLE.
- `hl_src_sel` = (kind==MULT) and `div_src_sel` are held constant from INIT through DONE. Both are 0 in IDLE and DZERO.
- `start` while `busy` is ignored; it is not queued.
- `abort`=1 in any state forces IDLE on the next edge.
  - No `hl_load`, `done` or `div_zero_exc` is produced afterwards.
  - Strobes asserted in the abort cycle still complete that cycle.
  - `abort` and `start` together in IDLE: `abort` wins and the block stays in IDLE.
- The counter is 8 bits wide, unsigned, and has no wrap.

## Timing
- Reset: while `reset`=0, state=IDLE, counter=0, kind=DIV, and every output is 0 immediately, without waiting for a clock edge. Reset mid-operation discards the operation.
- Cycle numbering: cycle 0 is the cycle in which `start` is sampled high in IDLE.
- Normal operation:
  - Cycle 1: INIT, init strobe.
  - Cycles 2..N+1: RUN.
  - Cycle N+2: `hl_load`.
  - Cycle N+3: `done`.
  - `busy`=1 for cycles 1..N+3.
- The earliest next `start` is accepted in cycle N+4.
- Divide by zero: cycle 1 `div_zero_exc`=1 and `busy`=1; cycle 2 IDLE. The earliest next `start` is accepted in cycle 2.
- All outputs are registered or decoded from state only. No combinational path exists from `start`, `op` or `divisor_zero` to any output.

## Test plan
- Reset, then MULT with `MULT_CYCLES`=32: `start` in cycle 0 -> `mult_init` in cycle 1, `hl_src_sel`=1 in cycles 1..35, `hl_load` in cycle 34, `done` in cycle 35, `busy` high exactly in cycles 1..35.
- DIVM with `DIV_CYCLES`=4, `divisor_zero`=0 -> `div_init` in cycle 1, `div_src_sel`=1 and `hl_src_sel`=0 in cycles 1..7, `hl_load` in cycle 6, `done` in cycle 7.
- DIV with `divisor_zero`=1 -> `div_zero_exc` in cycle 1 only; `div_init`, `hl_load` and `done` never assert; a new MULT `start` in cycle 2 is accepted.
- `start` pulses in cycles 3 and 10 during a 32-cycle MULT -> both ignored; exactly one `hl_load` and one `done`; `op`=3 `start` in IDLE -> `busy` stays 0.
- `abort` in cycle 5 of a DIV -> IDLE in cycle 6, no `hl_load` or `done`; `reset` driven low in cycle 20 of a MULT -> all outputs 0 before the next clock edge, and a new operation after reset release completes normally.
